asmd_seq_multiplier: RTL and testbench

//  Parametrised shift-add (ASMD) sequential multiplier; successor to the fixed 4-bit unit.

---
 rtl/asmd_pkg.sv | 12 +
 rtl/asmd_mult_datapath.sv | 77 +++++++
 rtl/asmd_seq_multiplier.sv | 91 +++++++++
 tb/tb_asmd_seq_multiplier.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/asmd_pkg.sv
// Shared constants for the ASMD shift-add multiplier.
// FSM state encodings and datapath operation codes.
package asmd_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/asmd_mult_datapath.sv
// Operand register, WORD_LEN+1 add/sub and shifting accumulator.
// Ports: load/step/last strobes, operands in, next-acc out; signed_i with ASMD_SIGNED_EN.
module asmd_mult_datapath
  import asmd_pkg::*;
#(
  parameter int WORD_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  last_i,
  input  logic [WORD_LEN-1:0]   mcand_i,
  input  logic [WORD_LEN-1:0]   mplier_i,
`ifdef ASMD_SIGNED_EN
  input  logic                  signed_i,
`endif
  output logic [2*WORD_LEN-1:0] acc_nxt_o
);

  localparam int W = WORD_LEN;

  logic [W-1:0]   mcand_q, mcand_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W:0]     hi_ext, mc_ext, addend, sum;
  logic           op;
  logic           sgn;

`ifdef ASMD_SIGNED_EN
  logic sgn_q, sgn_d;

  always_comb begin
    sgn_d = sgn_q;
    if (load_i) sgn_d = signed_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sgn_q <= 1'b0;
    else        sgn_q <= sgn_d;
  end

  assign sgn = sgn_q;
`else
  assign sgn = 1'b0;
`endif

  // Multiplier lives in the low half and is consumed LSB first.
  // Signed: the MSB weight is negative, so the last step subtracts.
  always_comb begin
    op      = (sgn & last_i) ? OP_SUB : OP_ADD;
    hi_ext  = {sgn & acc_q[2*W-1], acc_q[2*W-1:W]};
    mc_ext  = {sgn & mcand_q[W-1], mcand_q};
    addend  = acc_q[0] ? mc_ext : '0;
    sum     = (op == OP_SUB) ? hi_ext - addend
                             : hi_ext + addend;
    acc_nxt_o = {sum, acc_q[W-1:1]};
    mcand_d = mcand_q;
    acc_d   = acc_q;
    if (load_i) begin
      mcand_d = mcand_i;
      acc_d   = {{W{1'b0}}, mplier_i};
    end else if (step_i) begin
      acc_d   = acc_nxt_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: rtl/asmd_seq_multiplier.sv
// Shift-add sequential multiplier with start/ready handshake, WORD_LEN+2 cycles/op.
// Ports: clk, reset(n), start, word0, word1, [signed_mode if ASMD_SIGNED_EN], ready, busy, done, product.
module asmd_seq_multiplier
  import asmd_pkg::*;
#(
  parameter int WORD_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_LEN-1:0]   word0,
  input  logic [WORD_LEN-1:0]   word1,
`ifdef ASMD_SIGNED_EN
  input  logic                  signed_mode,
`endif
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [2*WORD_LEN-1:0] product
);

  localparam int CNT_W = $clog2(WORD_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_LEN - 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*WORD_LEN-1:0] product_q, product_d;
  logic [2*WORD_LEN-1:0] acc_nxt;
  logic                  load, step, last;

  // Product is captured from the final step so it is valid with done.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      state_q == S_RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          last      = 1'b1;
          product_d = acc_nxt;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  asmd_mult_datapath #(.WORD_LEN(WORD_LEN)) u_dp (
    .clk       (clk),
    .rst_n     (reset),
    .load_i    (load),
    .step_i    (step),
    .last_i    (last),
    .mcand_i   (word0),
    .mplier_i  (word1),
`ifdef ASMD_SIGNED_EN
    .signed_i  (signed_mode),
`endif
    .acc_nxt_o (acc_nxt)
  );

  assign ready   = (state_q == S_IDLE);
  assign busy    = ~ready;
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_asmd_seq_multiplier.sv
// Bench for asmd_seq_multiplier: WORD_LEN=4 and 8 instances.
// Random and directed ops checked against an integer-arithmetic model.
module tb_asmd_seq_multiplier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s4 = 1'b0, s8 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       m4 = 1'b0, m8 = 1'b0;
  logic       r4, y4, d4, r8, y8, d8;
  logic [7:0] p4;
  logic [15:0] p8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  asmd_seq_multiplier #(.WORD_LEN(4)) dut4 (
    .clk(clk), .reset(rst_n), .start(s4),
    .word0(a4), .word1(b4),
`ifdef ASMD_SIGNED_EN
    .signed_mode(m4),
`endif
    .ready(r4), .busy(y4), .done(d4), .product(p4)
  );

  asmd_seq_multiplier #(.WORD_LEN(8)) dut8 (
    .clk(clk), .reset(rst_n), .start(s8),
    .word0(a8), .word1(b8),
`ifdef ASMD_SIGNED_EN
    .signed_mode(m8),
`endif
    .ready(r8), .busy(y8), .done(d8), .product(p8)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input int w, input logic [7:0] x,
                                        input logic [7:0] y, input bit sm);
    longint sx, sy, p, msk;
    msk = (longint'(1) << w) - 1;
    sx = longint'(x) & msk;
    sy = longint'(y) & msk;
    if (sm && sx[w-1]) sx = sx - (longint'(1) << w);
    if (sm && sy[w-1]) sy = sy - (longint'(1) << w);
    p = sx * sy;
    return 16'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic logic [15:0] prod(input int w);
    return (w == 4) ? {8'h00, p4} : p8;
  endfunction

  function automatic logic rdy(input int w);
    return (w == 4) ? r4 : r8;
  endfunction

  function automatic logic bsy(input int w);
    return (w == 4) ? y4 : y8;
  endfunction

  function automatic logic dn(input int w);
    return (w == 4) ? d4 : d8;
  endfunction

  task automatic drv(input int w, input logic s, input logic [7:0] x,
                     input logic [7:0] y, input logic sm);
    if (w == 4) begin
      s4 = s; a4 = x[3:0]; b4 = y[3:0]; m4 = sm;
    end else begin
      s8 = s; a8 = x; b8 = y; m8 = sm;
    end
  endtask

  // One operation; done must rise WORD_LEN edges after the accept edge.
  task automatic op(input int w, input logic [7:0] x, input logic [7:0] y,
                    input bit sm, input bit poke);
    logic [15:0] exp;
    logic [15:0] held;
    int lat;
    exp = model(w, x, y, sm);
    lat = 0;
    @(negedge clk);
    chk("ready_before", {15'd0, rdy(w)}, 16'd1);
    drv(w, 1'b1, x, y, sm);
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      drv(w, poke && (k == 2), 8'($urandom), 8'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
      if (dn(w)) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      chk("done_timeout", 16'd0, 16'd1);
    end else begin
      chk("latency", 16'(lat), 16'(w));
      chk("product", prod(w), exp);
      chk("busy_in_done", {15'd0, bsy(w)}, 16'd1);
      held = prod(w);
      @(posedge clk);
      #1;
      chk("done_pulse", {15'd0, dn(w)}, 16'd0);
      chk("ready_after", {15'd0, rdy(w)}, 16'd1);
      chk("product_held", prod(w), held);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_r4"}, {15'd0, r4}, 16'd1);
    chk({tag, "_b4"}, {15'd0, y4}, 16'd0);
    chk({tag, "_d4"}, {15'd0, d4}, 16'd0);
    chk({tag, "_p4"}, {8'd0, p4}, 16'd0);
    chk({tag, "_r8"}, {15'd0, r8}, 16'd1);
    chk({tag, "_b8"}, {15'd0, y8}, 16'd0);
    chk({tag, "_d8"}, {15'd0, d8}, 16'd0);
    chk({tag, "_p8"}, p8, 16'd0);
  endtask

  bit sm_en;

  initial begin
`ifdef ASMD_SIGNED_EN
    sm_en = 1'b1;
`else
    sm_en = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("reset");

    op(4, 8'd15, 8'd12, 1'b0, 1'b0);
    op(8, 8'd255, 8'd255, 1'b0, 1'b0);
    op(8, 8'd0, 8'd200, 1'b0, 1'b0);
    op(4, 8'd9, 8'd6, 1'b0, 1'b1);

    // Reset two cycles into an operation.
    @(negedge clk);
    drv(4, 1'b1, 8'd7, 8'd9, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drv(4, 1'b0, 8'd0, 8'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_idle("midreset");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("midreset_nodone", {15'd0, d4}, 16'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("after_reset_nodone", {15'd0, d4}, 16'd0);
    op(4, 8'd3, 8'd5, 1'b0, 1'b0);

    if (sm_en) begin
      op(4, 8'h8, 8'h7, 1'b1, 1'b0);
      op(4, 8'hF, 8'hF, 1'b1, 1'b0);
      op(4, 8'hF, 8'hF, 1'b0, 1'b0);
      op(8, 8'h80, 8'h80, 1'b1, 1'b0);
    end

    for (int i = 0; i < 25; i++) begin
      op(4, 8'($urandom), 8'($urandom), sm_en & 1'($urandom), 1'($urandom));
      op(8, 8'($urandom), 8'($urandom), sm_en & 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
